// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: channel-side and output-side handshake bundle for rr_mux_n.
interface rr_mux_n_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_ch;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel mux with fixed-select or round-robin arbitration into a
// single registered output stage with valid/ready backpressure.
module rr_mux_n #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input logic        clk,
    input logic        rst,
    rr_mux_n_if.slave  bus
);
    logic          load;
    logic          gnt_v;
    logic [SW-1:0] gnt;
    logic [SW-1:0] ptr;

    assign load = !bus.out_valid || bus.out_ready;

    // Round-robin search runs high-to-low so the channel nearest ptr wins last.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        if (!bus.mode) begin
            gnt_v = |(bus.in_valid & (N'(1) << bus.sel));
            gnt   = bus.sel;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (bus.in_valid[SW'((int'(ptr) + k) % N)]) begin
                    gnt_v = 1'b1;
                    gnt   = SW'((int'(ptr) + k) % N);
                end
            end
        end
    end

    assign bus.in_ready = (load && gnt_v && !rst) ? N'(1) << gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= '0;
        end else if (load) begin
            bus.out_valid <= gnt_v;
            if (gnt_v) begin
                bus.out_data <= W'(bus.in_data >> (gnt * W));
                bus.out_ch   <= gnt;
                if (bus.mode) ptr <= (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed and randomized checks of rr_mux_n against a
// transaction-level model of the arbitration and output register.
module tb_rr_mux_n;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rr_mux_n_if #(.N(N), .W(W)) bus ();
    rr_mux_n #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Model state: the held word and the rotation pointer.
    logic          mv;
    logic [W-1:0]  md;
    int            mc;
    int            mp;

    function automatic void model_grant(output logic ok, output int g);
        ok = 1'b0;
        g  = 0;
        if (!bus.mode) begin
            if (int'(bus.sel) < N && bus.in_valid[bus.sel]) begin
                ok = 1'b1;
                g  = int'(bus.sel);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!ok && bus.in_valid[(mp + k) % N]) begin
                    ok = 1'b1;
                    g  = (mp + k) % N;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic ok;
        int   g;
        model_grant(ok, g);
        return (!rst && ok && (!mv || bus.out_ready)) ? (N'(1) << g) : '0;
    endfunction

    task automatic tick();
        logic         ok;
        logic         ld;
        logic         m;
        int           g;
        logic [W-1:0] d;
        model_grant(ok, g);
        ld = !mv || bus.out_ready;
        m  = bus.mode;
        d  = bus.in_data[g*W +: W];
        @(posedge clk);
        if (rst) begin
            mv = 1'b0; md = '0; mc = 0; mp = 0;
        end else if (ld) begin
            mv = ok;
            if (ok) begin
                md = d;
                mc = g;
                if (m) mp = (g + 1) % N;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = '1;
        bus.in_data   = 32'h44332211;
        bus.mode      = 1'b1;
        bus.sel       = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tests++;
        if (bus.in_ready !== '0) begin
            fails++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
        end
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_ch !== '0) begin
            fails++;
            $display("FAIL reset_out got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b0100;
        bus.in_data = 32'h00A50000; bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 4'b0100) begin
            fails++; $display("FAIL fixed_in_ready got %b want 0100", bus.in_ready);
        end
        tick();
        tests++;
        if (bus.out_data !== 8'hA5 || bus.out_ch !== 2'd2 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL fixed_out got d=%h ch=%0d v=%b want d=a5 ch=2 v=1",
                     bus.out_data, bus.out_ch, bus.out_valid);
        end
    endtask

    task automatic test_rr_all();
        int want [5] = '{0, 1, 2, 3, 0};
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        bus.in_data = 32'hD4C3B2A1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_ch) != want[i] || bus.out_ch !== SW'(mc)) begin
                fails++;
                $display("FAIL rr_all[%0d] got v=%b ch=%0d want v=1 ch=%0d",
                         i, bus.out_valid, bus.out_ch, want[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int want [3] = '{3, 0, 3};
        bus.mode = 1'b1; bus.out_ready = 1'b1; bus.in_data = 32'h33221100;
        do_reset();
        bus.in_valid = 4'b0001;
        tick();
        bus.in_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (int'(bus.out_ch) != want[i] || bus.out_data !== bus.in_data[want[i]*W +: W]) begin
                fails++;
                $display("FAIL wrap[%0d] got ch=%0d d=%h want ch=%0d", i, bus.out_ch, bus.out_data, want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] hd;
        logic [SW-1:0] hc;
        bus.mode = 1'b1; bus.in_valid = 4'b0110; bus.out_ready = 1'b1;
        bus.in_data = 32'h0BADF00D;
        tick();
        hd = bus.out_data; hc = bus.out_ch;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 4'(~i);
            bus.in_data  = $urandom;
            bus.mode     = i[0];
            bus.sel      = SW'(i);
            #1;
            tests++;
            if (bus.in_ready !== '0) begin
                fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready);
            end
            tick();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_ch !== hc) begin
                fails++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                         i, bus.out_valid, bus.out_data, bus.out_ch, hd, hc);
            end
        end
        bus.out_ready = 1'b1; bus.mode = 1'b1; bus.in_valid = 4'b1000;
        #1;
        tests++;
        if (bus.in_ready !== 4'b1000) begin
            fails++; $display("FAIL bp_release got %b want 1000", bus.in_ready);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3 || bus.out_data !== bus.in_data[31:24]) begin
            fails++;
            $display("FAIL bp_new got v=%b ch=%0d d=%h want v=1 ch=3 d=%h",
                     bus.out_valid, bus.out_ch, bus.out_data, bus.in_data[31:24]);
        end
    endtask

    task automatic test_no_grant();
        bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'b1101; bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== '0) begin
            fails++; $display("FAIL nogrant_in_ready got %b want 0", bus.in_ready);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL nogrant_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.mode = 1'b1; bus.out_ready = 1'b1; bus.in_data = 32'hCAFEBEEF;
        do_reset();
        bus.in_valid = 4'b0010;
        tick();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_ch !== '0) begin
            fails++;
            $display("FAIL rstmid_out got v=%b d=%h ch=%0d want 0/00/0",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        bus.out_ready = 1'b1; bus.in_valid = 4'b0110;
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1) begin
            fails++; $display("FAIL rstmid_first got v=%b ch=%0d want v=1 ch=1", bus.out_valid, bus.out_ch);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 39) == 0);
            bus.in_data   = $urandom;
            bus.in_valid  = N'($urandom);
            bus.mode      = ($urandom_range(0, 3) != 0);
            bus.sel       = SW'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = exp_ready();
            tests++;
            if (bus.in_ready !== er) begin
                fails++; $display("FAIL rand_ready[%0d] got %b want %b", i, bus.in_ready, er);
            end
            tick();
            tests++;
            if (bus.out_valid !== mv || bus.out_data !== md || bus.out_ch !== SW'(mc)) begin
                fails++;
                $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                         i, bus.out_valid, bus.out_data, bus.out_ch, mv, md, mc);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        mv = 1'b0; md = '0; mc = 0; mp = 0;
        test_reset();
        test_fixed();
        test_rr_all();
        test_wrap();
        test_backpressure();
        test_no_grant();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_mux_n.md
RR_MUX_N -- requirements
Module: rr_mux_n

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning input channel count (legal 2..16).
REQ-002 The block SHALL have parameter W, default 8, meaning data width per channel.
REQ-003 The block SHALL have derived parameter SW, default $clog2(N), meaning select/channel-index width.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-007 The block SHALL have port in_valid  input  N  per-channel data valid.
REQ-008 The block SHALL have port in_ready  output  N  per-channel accept strobe.
REQ-009 The block SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 The block SHALL have port sel  input  SW  channel index used in mode 0.
REQ-011 The block SHALL have port out_data  output  W  registered selected data.
REQ-012 The block SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-013 The block SHALL have port out_ready  input  1  downstream accepts word when high with out_valid.
REQ-014 The block SHALL have port out_ch  output  SW  source channel index of out_data.

Function
REQ-015 The block SHALL define load = !out_valid || out_ready; the output register SHALL update only when load is high.
REQ-016 In mode 0, the block SHALL grant channel sel when in_valid[sel] is high and sel < N; otherwise it SHALL make no grant.
REQ-017 In mode 1, the block SHALL grant the first channel i with in_valid[i] high, searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap-around mod N).
REQ-018 The block SHALL hold an internal rotation pointer ptr (SW bits); on every mode-1 transfer from channel g it SHALL set ptr = (g+1) mod N, including g = N-1 -> 0.
REQ-019 The block SHALL leave ptr unchanged on mode-0 transfers and on cycles with no grant.
REQ-020 The block SHALL drive in_ready[g] = load && grant valid for granted channel g, and all other in_ready bits 0; in_ready SHALL be combinational and SHALL NOT depend on in_valid of non-granted channels.
REQ-021 A transfer SHALL occur when in_valid[g] && in_ready[g]; on that edge out_data <= in_data[g], out_ch <= g, and out_valid <= 1.
REQ-022 When load is high and there is no grant, the block SHALL set out_valid <= 0 and hold out_data and out_ch.
REQ-023 When out_valid && !out_ready, the block SHALL hold out_data, out_ch and out_valid stable and drive all in_ready to 0 (backpressure).
REQ-024 Latency SHALL be 1 cycle from transfer to out_valid; sustained throughput SHALL be 1 word/cycle when out_ready stays high.
REQ-025 Changes to mode or sel SHALL affect only the next grant, never a word already held in the output register.
REQ-026 When all in_valid bits are 0, the block SHALL make no grant and leave ptr unchanged.

Reset
REQ-027 While rst is high at a clock edge, the block SHALL set out_valid = 0, out_data = 0, out_ch = 0 and ptr = 0, and SHALL drive in_ready = 0 during that cycle.
REQ-028 Asserting rst while a word is held SHALL discard that word; no transfer SHALL be counted in that cycle.
REQ-029 After rst deasserts, the first mode-1 grant SHALL search from channel 0.

Verification
REQ-030 Mode 0, N=4, W=8, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2, out_valid=1.
REQ-031 Mode 1, in_valid=4'b1111 constant, out_ready=1 from reset -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 Mode 1, in_valid=4'b1001, ptr=1 -> grant ch3, then ch0 (wrap), then ch3.
REQ-033 out_valid=1, out_ready=0 for 3 cycles with inputs toggling -> out_data/out_ch unchanged, in_ready=0; on out_ready=1 the held word is consumed and a new grant is made in that same cycle.
REQ-034 Mode 0, sel=1, in_valid[1]=0 with other channels valid -> no grant, out_valid falls to 0 after the held word is consumed.
REQ-035 rst pulsed while out_valid=1 and ptr=2 -> next cycle out_valid=0, out_data=0, out_ch=0; first mode-1 grant comes from the lowest valid channel at or above ch0.
